// File: rtl/cpu_pkg.sv
// Shared types and widths for the call/return sequencer and its return-address store.
package cpu_pkg;
    localparam int SP_WIDTH     = 6;
    localparam int PC_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CALL_PUSH = 2'd1,
        S_RET_RD    = 2'd2,
        S_RET_POP   = 2'd3
    } cs_state_t;
endpackage

// File: rtl/ret_addr_lifo.sv
// Return-address storage: DEPTH x PC_WIDTH registers, one write port, one async read port.
module ret_addr_lifo #(
    parameter int DEPTH    = 16,
    parameter int PC_WIDTH = 8,
    parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [PC_WIDTH-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [PC_WIDTH-1:0] rdata
);
    logic [PC_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/call_stack_ctrl.sv
// CALL/RET sequencer: owns the frame pointer, drives register-file stack strobes and PC loads.
module call_stack_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                call_req,
    input  logic                ret_req,
    input  logic [PC_WIDTH-1:0] call_target,
    input  logic [PC_WIDTH-1:0] pc_ret,
    output logic                pc_load,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                rf_stack_push,
    output logic                rf_stack_pop,
    output logic [SP_WIDTH-1:0] rf_stack_pointer,
    output logic                busy,
    output logic                overflow,
    output logic                underflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_WIDTH-1:0] DEPTH_SP = SP_WIDTH'(DEPTH);

    cs_state_t           state, state_nx;
    logic [SP_WIDTH-1:0] sp;
    logic [PC_WIDTH-1:0] tgt_q, ret_q, rd_data;
    logic                call_ok, ret_ok;

    assign call_ok = call_req && (sp < DEPTH_SP);
    assign ret_ok  = !call_req && ret_req && (sp != '0);

    ret_addr_lifo #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .AW(AW)) u_lifo (
        .clk   (clk),
        .we    (state == S_CALL_PUSH),
        .waddr (sp[AW-1:0]),
        .wdata (ret_q),
        .raddr (AW'(sp - SP_WIDTH'(1))),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sp        <= '0;
            tgt_q     <= '0;
            ret_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (call_ok) begin
                        tgt_q <= call_target;
                        ret_q <= pc_ret;
                    end
                    // Only a blocked request raises a flag; CALL wins so a dropped RET never does.
                    if (call_req && !call_ok) overflow <= 1'b1;
                    if (!call_req && ret_req && sp == '0) underflow <= 1'b1;
                end
                S_CALL_PUSH: sp <= sp + SP_WIDTH'(1);
                S_RET_POP:   sp <= sp - SP_WIDTH'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx         = state;
        pc_load          = 1'b0;
        pc_out           = '0;
        rf_stack_push    = 1'b0;
        rf_stack_pop     = 1'b0;
        rf_stack_pointer = sp;
        busy             = 1'b0;
        case (state)
            S_IDLE: begin
                if (call_ok)     state_nx = S_CALL_PUSH;
                else if (ret_ok) state_nx = S_RET_RD;
            end
            S_CALL_PUSH: begin
                state_nx         = S_IDLE;
                rf_stack_pointer = sp + SP_WIDTH'(1);
                rf_stack_push    = 1'b1;
                pc_load          = 1'b1;
                pc_out           = tgt_q;
                busy             = 1'b1;
            end
            S_RET_RD: begin
                state_nx = S_RET_POP;
                busy     = 1'b1;
            end
            S_RET_POP: begin
                state_nx     = S_IDLE;
                rf_stack_pop = 1'b1;
                pc_load      = 1'b1;
                pc_out       = rd_data;
                busy         = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_call_stack_ctrl.sv
// Randomized bench for call_stack_ctrl against a queue-based LIFO model.
module tb_call_stack_ctrl;
    localparam int PCW   = 8;
    localparam int DEPTH = 16;

    logic           clk = 0;
    logic           rst, call_req, ret_req;
    logic [PCW-1:0] call_target, pc_ret, pc_out;
    logic           pc_load, rf_stack_push, rf_stack_pop, busy, overflow, underflow;
    logic [5:0]     rf_stack_pointer;

    int n_vec = 0;
    int n_err = 0;

    logic [PCW-1:0] q[$];
    logic           m_ovf, m_unf;

    call_stack_ctrl #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
        .call_target(call_target), .pc_ret(pc_ret), .pc_load(pc_load), .pc_out(pc_out),
        .rf_stack_push(rf_stack_push), .rf_stack_pop(rf_stack_pop),
        .rf_stack_pointer(rf_stack_pointer), .busy(busy),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".push"}, 32'(rf_stack_push), 0);
        chk({tag, ".pop"}, 32'(rf_stack_pop), 0);
        chk({tag, ".pcld"}, 32'(pc_load), 0);
        chk({tag, ".sp"}, 32'(rf_stack_pointer), 32'(q.size()));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic do_reset();
        rst = 1; call_req = 0; ret_req = 0;
        step();
        rst = 0;
        q.delete(); m_ovf = 0; m_unf = 0;
    endtask

    // Issue one request in IDLE and follow it to completion against the model.
    task automatic do_op(input bit c, input bit r, input logic [PCW-1:0] tgt, input logic [PCW-1:0] ra);
        call_req = c; ret_req = r; call_target = tgt; pc_ret = ra;
        step();
        call_req = 0; ret_req = 0;
        if (c) begin
            if (q.size() < DEPTH) begin
                chk("call.push", 32'(rf_stack_push), 1);
                chk("call.pcld", 32'(pc_load), 1);
                chk("call.pc", 32'(pc_out), 32'(tgt));
                chk("call.sp", 32'(rf_stack_pointer), 32'(q.size() + 1));
                chk("call.busy", 32'(busy), 1);
                chk("call.pop", 32'(rf_stack_pop), 0);
                q.push_back(ra);
                step();
                chk_quiet("call.done");
            end else begin
                m_ovf = 1;
                chk_quiet("call.ovf");
            end
        end else if (r) begin
            if (q.size() > 0) begin
                chk("ret.rd.busy", 32'(busy), 1);
                chk("ret.rd.strb", 32'({rf_stack_pop, rf_stack_push, pc_load}), 0);
                chk("ret.rd.sp", 32'(rf_stack_pointer), 32'(q.size()));
                step();
                chk("ret.pop", 32'(rf_stack_pop), 1);
                chk("ret.pcld", 32'(pc_load), 1);
                chk("ret.pc", 32'(pc_out), 32'(q[$]));
                chk("ret.sp", 32'(rf_stack_pointer), 32'(q.size()));
                chk("ret.busy", 32'(busy), 1);
                void'(q.pop_back());
                step();
                chk_quiet("ret.done");
            end else begin
                m_unf = 1;
                chk_quiet("ret.unf");
            end
        end else begin
            chk_quiet("nop");
        end
    endtask

    initial begin
        call_target = 0; pc_ret = 0;
        do_reset();
        chk("rst.pc", 32'(pc_out), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_quiet("idle");
        end

        do_op(1, 0, 8'h40, 8'h11);
        do_op(0, 1, 8'h00, 8'h00);

        do_op(1, 0, 8'h50, 8'h11);
        do_op(1, 0, 8'h60, 8'h22);
        do_op(1, 0, 8'h70, 8'h33);
        for (int i = 0; i < 3; i++) do_op(0, 1, 8'h00, 8'h00);

        for (int i = 0; i < DEPTH; i++) do_op(1, 0, 8'(8'h80 + i), 8'(8'hA0 + i));
        do_op(1, 0, 8'hEE, 8'hEE);
        do_op(0, 1, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH; i++) do_op(0, 1, 8'h00, 8'h00);
        do_op(0, 1, 8'h00, 8'h00);
        do_op(1, 1, 8'h12, 8'h34);
        do_op(0, 1, 8'h00, 8'h00);

        // Abort a RET in its read cycle.
        do_reset();
        do_op(1, 0, 8'h01, 8'h02);
        do_op(1, 0, 8'h03, 8'h04);
        ret_req = 1;
        step();
        ret_req = 0;
        chk("abort.rd.busy", 32'(busy), 1);
        rst = 1;
        step();
        rst = 0;
        q.delete(); m_ovf = 0; m_unf = 0;
        chk_quiet("abort");
        step();
        chk_quiet("abort.next");

        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                do_reset();
                chk_quiet("rnd.rst");
            end else if (sel < 50) begin
                do_op(1, sel < 8, 8'($urandom), 8'($urandom));
            end else if (sel < 95) begin
                do_op(0, 1, 8'($urandom), 8'($urandom));
            end else begin
                do_op(0, 0, 8'($urandom), 8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
